// File: rtl/pe_fork_pipe.sv
// pe_fork_pipe: LATENCY-stage elastic pipeline with one valid/ready input
// forked to NUM_OUT valid/ready outputs. A token retires only once every
// channel has taken it. Bubbles collapse, so upstream stages keep filling while
// the output stage stalls. Unstalled latency is LATENCY cycles and throughput is
// 1 token/cycle. Backpressure: in_ready drops only when every stage holds a
// token and the output stage cannot retire this cycle.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of in-flight tokens)
//   in_data/in_valid/in_ready  : single producer handshake
//   out_data                   : output-stage data shared by all channels
//   out_valid/out_ready        : per-channel consumer handshake
//   occupancy                  : registered count of valid stages
module pe_fork_pipe #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 15,
   parameter int NUM_OUT = 2,
   localparam int OCC_W  = $clog2(LATENCY + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [NUM_OUT-1:0] out_valid,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic [OCC_W-1:0]   occupancy
);

   logic [WIDTH-1:0]   data_q [LATENCY];
   logic [LATENCY-1:0] v_q;
   logic [LATENCY-1:0] v_nxt;
   logic [LATENCY-1:0] adv;
   logic [NUM_OUT-1:0] sent_q;
   logic [NUM_OUT-1:0] sent_nxt;
   logic [OCC_W-1:0]   occ_nxt;
   logic               done_all;

   assign out_data  = data_q[LATENCY-1];
   assign out_valid = {NUM_OUT{v_q[LATENCY-1]}} & ~sent_q;

   // Channels that already took the token count as accepting, so the token
   // retires on the cycle the last outstanding channel takes it.
   assign done_all = v_q[LATENCY-1] & (&(sent_q | out_ready));

   // A stage may advance if it is a bubble or everything downstream of it
   // advances. Built as a running OR from the output stage backwards.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = ~v_q[LATENCY-1] | done_all;
      adv[LATENCY-1] = chain;
      for (int s = LATENCY - 2; s >= 0; s--) begin
         chain  = chain | ~v_q[s];
         adv[s] = chain;
      end
   end

   assign in_ready = adv[0] & ~flush;

   always_comb begin
      v_nxt    = v_q;
      sent_nxt = sent_q;
      if (flush) begin
         v_nxt    = '0;
         sent_nxt = '0;
      end else begin
         if (adv[0]) begin
            v_nxt[0] = in_valid & in_ready;
         end
         for (int s = 1; s < LATENCY; s++) begin
            if (adv[s]) begin
               v_nxt[s] = v_q[s-1];
            end
         end
         sent_nxt = done_all ? '0 : (sent_q | (out_valid & out_ready));
      end
   end

   // Occupancy tracks the post-edge valid vector, so it is computed from v_nxt.
   always_comb begin
      occ_nxt = '0;
      for (int s = 0; s < LATENCY; s++) begin
         occ_nxt = occ_nxt + OCC_W'(v_nxt[s]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q       <= '0;
         sent_q    <= '0;
         occupancy <= '0;
      end else begin
         v_q       <= v_nxt;
         sent_q    <= sent_nxt;
         occupancy <= occ_nxt;
      end
   end

   // Bubble stages may keep stale data; out_valid masks it at the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) begin
            data_q[s] <= '0;
         end
      end else if (!flush) begin
         if (in_valid && in_ready) begin
            data_q[0] <= in_data;
         end
         for (int s = 1; s < LATENCY; s++) begin
            if (adv[s]) begin
               data_q[s] <= data_q[s-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_pe_fork_pipe.sv
module tb_pe_fork_pipe;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [3:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   pe_fork_pipe #(.WIDTH(16), .LATENCY(15), .NUM_OUT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 2'b00;
      #1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int exp_acc;
      int exp_ret;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 2'b00;
      #12;
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 2'b00);
      check("rst_out_data",  out_data,  16'h0000);
      check("rst_occupancy", occupancy, 4'd0);
      check("rst_in_ready",  in_ready,  1'b1);

      // Fill and stream 0x0001..0x0020 with both channels always ready.
      tick();
      do_reset();
      out_ready = 2'b11;
      for (int e = 0; e < 48; e++) begin
         in_valid = (e < 32);
         in_data  = 16'(e + 1);
         #1;
         check("t1_in_ready", in_ready, 1'b1);
         tick();
         exp_acc = (e + 1 < 32) ? e + 1 : 32;
         exp_ret = e - 14;
         if (exp_ret < 0)  exp_ret = 0;
         if (exp_ret > 32) exp_ret = 32;
         check("t1_occupancy", occupancy, 32'(exp_acc - exp_ret));
         if (e >= 14 && e < 46) begin
            check("t1_out_valid", out_valid, 2'b11);
            check("t1_out_data",  out_data,  32'(e - 13));
         end else begin
            check("t1_out_idle", out_valid, 2'b00);
         end
      end

      // Fork skew: ch0 takes the token, ch1 releases it five cycles later.
      do_reset();
      out_ready = 2'b01;
      for (int e = 0; e < 22; e++) begin
         in_valid = (e < 3);
         in_data  = 16'(e + 1);
         if (e == 20) out_ready = 2'b10;
         tick();
         if (e == 14) begin
            check("t2_first_valid", out_valid, 2'b11);
            check("t2_first_data",  out_data,  16'h0001);
         end
         if (e >= 15 && e <= 19) begin
            check("t2_skew_valid", out_valid, 2'b10);
            check("t2_skew_data",  out_data,  16'h0001);
         end
         if (e == 20) begin
            check("t2_next_valid", out_valid, 2'b11);
            check("t2_next_data",  out_data,  16'h0002);
            check("t2_next_occ",   occupancy, 4'd2);
         end
         if (e == 21) begin
            check("t2_ch1_took_valid", out_valid, 2'b01);
            check("t2_ch1_took_data",  out_data,  16'h0002);
         end
      end

      // Full backpressure, then release with simultaneous accept and retire.
      do_reset();
      begin
         int nxt;
         nxt = 1;
         in_valid = 1'b1;
         for (int c = 0; c < 20; c++) begin
            in_data = 16'(nxt);
            #1;
            check("t3_fill_in_ready", in_ready, (c < 15) ? 1'b1 : 1'b0);
            if (c < 15) nxt++;
            tick();
         end
         check("t3_full_occ", occupancy, 4'd15);
         out_ready = 2'b11;
         for (int c = 0; c < 20; c++) begin
            in_data = 16'(16 + c);
            #1;
            check("t3_rel_in_ready",  in_ready,  1'b1);
            check("t3_rel_out_valid", out_valid, 2'b11);
            check("t3_rel_out_data",  out_data,  32'(c + 1));
            tick();
            check("t3_rel_occ", occupancy, 4'd15);
         end
         in_valid = 1'b0;
      end

      // Bubble collapse: two tokens four idle cycles apart end up adjacent.
      do_reset();
      for (int e = 0; e < 21; e++) begin
         in_valid = (e == 0 || e == 5);
         in_data  = (e == 0) ? 16'hAAAA : 16'hBBBB;
         tick();
      end
      in_valid = 1'b0;
      check("t4_occ",        occupancy, 4'd2);
      check("t4_a_valid",    out_valid, 2'b11);
      check("t4_a_data",     out_data,  16'hAAAA);
      out_ready = 2'b11;
      tick();
      check("t4_b_valid",    out_valid, 2'b11);
      check("t4_b_data",     out_data,  16'hBBBB);
      tick();
      check("t4_empty_valid", out_valid, 2'b00);
      check("t4_empty_occ",   occupancy, 4'd0);

      // Flush with 7 tokens in flight and a pending input.
      do_reset();
      for (int e = 0; e < 9; e++) begin
         in_valid = (e < 7);
         in_data  = 16'(16'h0050 + e);
         tick();
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      #1;
      check("t5_flush_in_ready", in_ready,  1'b0);
      check("t5_pre_flush_occ",  occupancy, 4'd7);
      tick();
      flush = 1'b0;
      check("t5_post_occ",   occupancy, 4'd0);
      check("t5_post_valid", out_valid, 2'b00);
      out_ready = 2'b11;
      #1;
      check("t5_resume_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 15; k++) begin
         tick();
         in_valid = 1'b0;
         if (k == 0)  check("t5_accept_occ", occupancy, 4'd1);
         if (k == 13) check("t5_early_valid", out_valid, 2'b00);
         if (k == 14) begin
            check("t5_out_valid", out_valid, 2'b11);
            check("t5_out_data",  out_data,  16'h1234);
         end
      end

      // Asynchronous reset with 9 tokens stalled in flight.
      do_reset();
      for (int e = 0; e < 15; e++) begin
         in_valid = (e < 9);
         in_data  = 16'(16'hC000 + e);
         tick();
      end
      in_valid = 1'b0;
      check("t6_pre_occ",   occupancy, 4'd9);
      check("t6_pre_valid", out_valid, 2'b11);
      check("t6_pre_data",  out_data,  16'hC000);
      #2;
      rst = 1'b1;
      #1;
      check("t6_arst_valid", out_valid, 2'b00);
      check("t6_arst_occ",   occupancy, 4'd0);
      check("t6_arst_data",  out_data,  16'h0000);
      #1;
      rst       = 1'b0;
      out_ready = 2'b11;
      in_valid  = 1'b1;
      in_data   = 16'hBEEF;
      for (int e = 0; e < 15; e++) begin
         tick();
         in_valid = 1'b0;
         if (e == 13) check("t6_early_valid", out_valid, 2'b00);
         if (e == 14) begin
            check("t6_lat_valid", out_valid, 2'b11);
            check("t6_lat_data",  out_data,  16'hBEEF);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_fork_pipe.md
Name: pe_fork_pipe

Overview:
- Parametrised successor to the fixed 1-in/2-out delay PE. It is a LATENCY-stage elastic pipeline with one valid/ready input and NUM_OUT valid/ready fork outputs.
- Each output channel must take every token exactly once. A token leaves the pipeline only after all channels have accepted it.
- Adds backpressure, bubble collapsing, a synchronous flush and an occupancy report. It sits between dataflow actors in the BDF graph wherever one producer feeds several consumers with a fixed compute latency.

Parameters:
- WIDTH, 16, data width in bits (>=1).
- LATENCY, 15, number of register stages (>=1); unstalled input-to-output latency in cycles.
- NUM_OUT, 2, number of fork output channels (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all in-flight tokens.
- in_data  input  WIDTH  input token data.
- in_valid  input  1  input token present.
- in_ready  output  1  pipeline accepts the token this cycle.
- out_data  output  WIDTH  data of output-stage token, shared by all channels.
- out_valid  output  NUM_OUT  per-channel token pending.
- out_ready  input  NUM_OUT  per-channel consumer accepts.
- occupancy  output  $clog2(LATENCY+1)  number of valid stages.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - Stage valid bits are 0. Stage data registers are 0.
  - The sent vector is 0, so out_valid = 0 and out_data = 0.
  - occupancy = 0. in_ready = 1 after reset deasserts (combinational from empty state).
- Storage:
  - Stage s (0..LATENCY-1) holds data_q[s] and v_q[s]. Stage LATENCY-1 is the output stage.
  - out_data = data_q[LATENCY-1].
- Fork bookkeeping:
  - sent_q[NUM_OUT] marks the channels that have already taken the current output-stage token.
  - out_valid[j] = v_q[LATENCY-1] & ~sent_q[j].
  - A channel transfer on j occurs when out_valid[j] & out_ready[j].
  - done_all = v_q[LATENCY-1] & &(sent_q | out_ready). The output stage empties this cycle when done_all is true.
  - If done_all is false: sent_q |= (out_valid & out_ready).
  - If done_all is true: sent_q <= 0.
- Advance rule (bubble-collapsing):
  - adv[LATENCY-1] = ~v_q[LATENCY-1] | done_all.
  - adv[s] = ~v_q[s] | adv[s+1] for s < LATENCY-1.
  - For s > 0, when adv[s]: data_q[s] <= data_q[s-1] and v_q[s] <= v_q[s-1].
  - For stage 0: in_ready = adv[0] & ~flush. When adv[0], v_q[0] <= in_valid & in_ready. data_q[0] loads in_data only on an accepted transfer.
  - Data registers of bubble stages may hold stale data. They are never observed, because out_valid gates them.
- Latency:
  - A token accepted at edge t presents out_valid on all channels after edge t+LATENCY-1, i.e. LATENCY cycles from acceptance with no stalls.
  - Throughput is 1 token/cycle when all out_ready are held high.
- Ordering: tokens are delivered in acceptance order on every channel. No token is duplicated or dropped on any channel.
- Stall: when any channel withholds ready, the output stage holds. Upstream stages keep filling bubbles until the pipeline is full, then in_ready = 0.
- Simultaneous events:
  - A channel that already took the token is ignored; out_ready on it is don't-care.
  - When all remaining channels accept in the same cycle, the token retires and the next token (if any) moves in on the same edge. sent_q returns to 0.
  - Input accept and output retire in the same cycle on a full pipeline is legal: in_ready = 1 in that cycle.
- Flush:
  - On the next edge all v_q and sent_q are cleared and occupancy becomes 0.
  - in_ready = 0 while flush is high. An in_valid during flush is not consumed.
  - out_valid may be high in the flush cycle, and a transfer in that cycle counts as delivered to the consumer.
  - flush has priority over every other update.
- occupancy: registered popcount of v_q, updated every edge. It is consistent with the v_q state after that edge.
- Reset mid-operation: rst assertion clears all state immediately (asynchronously). Outputs go to their reset values without waiting for clk.
- LATENCY=1: the single stage is both input and output stage. in_ready = ~v_q[0] | done_all.
- NUM_OUT=1: the block degenerates to an elastic delay line.
- Protocol assumption on the environment: once in_valid is raised it holds until accepted, with in_data stable. The block guarantees the same on out_valid[j] and out_data.

Test Plan:
- Reset and fill: WIDTH=16, LATENCY=15, NUM_OUT=2, out_ready=2'b11. Drive 0x0001..0x0020, one per cycle. -> First out_valid=2'b11 with data 0x0001, 15 cycles after first accept. Both channels see 0x0001..0x0020 in order, one per cycle, and occupancy peaks at 15.
- Fork skew: out_ready=2'b01 for 5 cycles, then 2'b10. -> Channel 0 takes 0x0001 once, then out_valid=2'b10 for the following cycles with data held at 0x0001. The token retires when ch1 accepts, and the next token appears the following cycle.
- Full backpressure: out_ready=2'b00 while in_valid=1 continuously. -> in_ready falls after 15 accepts and occupancy=15. Releasing out_ready=2'b11 gives in_ready=1 in the same cycle, with 1 retire and 1 accept per cycle and no loss.
- Bubble collapse: inject tokens 0xAAAA, idle 4 cycles, then 0xBBBB, with out_ready stalled until both are inside. -> Both occupy adjacent top stages (occupancy=2). They are delivered back-to-back 0xAAAA then 0xBBBB on both channels.
- Flush: with 7 tokens in flight, pulse flush for 1 cycle while in_valid=1 and data=0x1234. -> in_ready=0 in that cycle, and occupancy=0 and out_valid=0 after the edge. 0x1234 is accepted only after flush drops.
- Async reset mid-stream: assert rst between clock edges with occupancy=9. -> out_valid=0, occupancy=0 and out_data=0 immediately. After release, the first accepted token emerges after exactly LATENCY cycles.
